// File: rtl/bullet_pool.sv
// bullet_pool: fixed pool of NUM_BULLETS projectiles updated once per frame.
// Optional macro BULLET_POOL_WRAP_EN: playfield edges wrap instead of retiring.
module bullet_pool #(
  parameter int NUM_BULLETS = 4,
  parameter int POS_W       = 10,
  parameter int STEP_W      = 4,
  parameter int LIFE_W      = 8,
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  localparam int IDX_W      = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1,
  localparam int CNT_W      = $clog2(NUM_BULLETS + 1)
) (
  input  logic                         frameClk,
  input  logic                         reset,
  input  logic                         spawnReq,
  input  logic [1:0]                   spawnDir,
  input  logic [POS_W-1:0]             spawnX,
  input  logic [POS_W-1:0]             spawnY,
  input  logic [STEP_W-1:0]            spawnStep,
  input  logic [LIFE_W-1:0]            spawnLife,
  output logic                         spawnAck,
  output logic [IDX_W-1:0]             spawnIdx,
  output logic                         poolFull,
  input  logic [NUM_BULLETS-1:0]       killVec,
  input  logic [NUM_BULLETS-1:0]       bounceVec,
  output logic [NUM_BULLETS-1:0]       existsVec,
  output logic [NUM_BULLETS*POS_W-1:0] posXFlat,
  output logic [NUM_BULLETS*POS_W-1:0] posYFlat,
  output logic [2*NUM_BULLETS-1:0]     dirFlat,
  output logic [CNT_W-1:0]             activeCount
);

  // Two guard bits keep both underflow and step overflow visible in the sign.
  localparam int SW = POS_W + 2;
  localparam logic signed [SW-1:0] SCR_W_S = SW'(SCREEN_W);
  localparam logic signed [SW-1:0] SCR_H_S = SW'(SCREEN_H);

  logic [IDX_W-1:0] grant_idx;
  logic             grant_found;

  always_comb begin
    grant_idx   = '0;
    grant_found = 1'b0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      if (!grant_found && !existsVec[i]) begin
        grant_found = 1'b1;
        grant_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    activeCount = '0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      activeCount = activeCount + CNT_W'(existsVec[i]);
    end
  end

  assign poolFull = &existsVec;
  assign spawnAck = spawnReq & ~poolFull;
  assign spawnIdx = spawnAck ? grant_idx : '0;

  generate
    for (genvar gi = 0; gi < NUM_BULLETS; gi++) begin : gen_slot
      logic              exists_q, exists_d;
      logic [POS_W-1:0]  x_q, x_d, y_q, y_d;
      logic [1:0]        dir_q, dir_d, move_dir;
      logic [STEP_W-1:0] step_q, step_d;
      logic [LIFE_W-1:0] life_q, life_d, bcnt_q, bcnt_d;
      logic signed [SW-1:0] nx, ny, wx, wy;
      logic              spawn_here, bounce_retire, edge_retire;

      assign spawn_here    = spawnAck && (grant_idx == IDX_W'(gi));
      assign bounce_retire = bounceVec[gi] && (bcnt_q == life_q);
      // XOR with 1 swaps UP<->DOWN and LEFT<->RIGHT.
      assign move_dir      = (bounceVec[gi] && !bounce_retire) ? (dir_q ^ 2'b01) : dir_q;

      always_comb begin
        nx = SW'(x_q);
        ny = SW'(y_q);
        case (move_dir)
          2'd0:    ny = SW'(y_q) - SW'(step_q);
          2'd1:    ny = SW'(y_q) + SW'(step_q);
          2'd2:    nx = SW'(x_q) - SW'(step_q);
          default: nx = SW'(x_q) + SW'(step_q);
        endcase
`ifdef BULLET_POOL_WRAP_EN
        wx = (nx < 0) ? nx + SCR_W_S : (nx >= SCR_W_S) ? nx - SCR_W_S : nx;
        wy = (ny < 0) ? ny + SCR_H_S : (ny >= SCR_H_S) ? ny - SCR_H_S : ny;
        edge_retire = 1'b0;
`else
        wx = nx;
        wy = ny;
        edge_retire = (nx < 0) || (nx >= SCR_W_S) || (ny < 0) || (ny >= SCR_H_S);
`endif
      end

      always_comb begin
        exists_d = exists_q;
        x_d      = x_q;
        y_d      = y_q;
        dir_d    = dir_q;
        step_d   = step_q;
        life_d   = life_q;
        bcnt_d   = bcnt_q;
        if (spawn_here) begin
          exists_d = 1'b1;
          x_d      = spawnX;
          y_d      = spawnY;
          dir_d    = spawnDir;
          step_d   = spawnStep;
          life_d   = spawnLife;
          bcnt_d   = '0;
        end else if (exists_q) begin
          if (killVec[gi] || bounce_retire) begin
            exists_d = 1'b0;
          end else begin
            if (bounceVec[gi]) begin
              bcnt_d = bcnt_q + 1'b1;
              dir_d  = move_dir;
            end
            if (edge_retire) begin
              exists_d = 1'b0;
            end else begin
              x_d = wx[POS_W-1:0];
              y_d = wy[POS_W-1:0];
            end
          end
        end
      end

      always_ff @(posedge frameClk) begin
        if (reset) begin
          exists_q <= 1'b0;
          x_q      <= '0;
          y_q      <= '0;
          dir_q    <= 2'd3;
          step_q   <= '0;
          life_q   <= '0;
          bcnt_q   <= '0;
        end else begin
          exists_q <= exists_d;
          x_q      <= x_d;
          y_q      <= y_d;
          dir_q    <= dir_d;
          step_q   <= step_d;
          life_q   <= life_d;
          bcnt_q   <= bcnt_d;
        end
      end

      assign existsVec[gi]               = exists_q;
      assign posXFlat[gi*POS_W +: POS_W] = x_q;
      assign posYFlat[gi*POS_W +: POS_W] = y_q;
      assign dirFlat[gi*2 +: 2]          = dir_q;
    end
  endgenerate

endmodule

// File: tb/tb_bullet_pool.sv
// Directed bench for bullet_pool; expectations are queued at stimulus time
// and popped against the DUT outputs when they become valid.
module tb_bullet_pool;
  localparam int NB = 4;
  localparam int PW = 10;
  localparam int SW_ = 4;
  localparam int LW = 8;

  localparam int K_ACK = 0, K_IDX = 1, K_FULL = 2, K_CNT = 3, K_EXISTS = 4,
                 K_PX = 5, K_PY = 6, K_DIR = 7, K_DIRALL = 8;

  logic frameClk = 1'b0;
  logic reset = 1'b1;
  logic spawnReq = 1'b0;
  logic [1:0] spawnDir = 2'd0;
  logic [PW-1:0] spawnX = '0, spawnY = '0;
  logic [SW_-1:0] spawnStep = '0;
  logic [LW-1:0] spawnLife = '0;
  logic spawnAck;
  logic [1:0] spawnIdx;
  logic poolFull;
  logic [NB-1:0] killVec = '0, bounceVec = '0;
  logic [NB-1:0] existsVec;
  logic [NB*PW-1:0] posXFlat, posYFlat;
  logic [2*NB-1:0] dirFlat;
  logic [2:0] activeCount;

  bullet_pool dut (
    .frameClk(frameClk), .reset(reset), .spawnReq(spawnReq), .spawnDir(spawnDir),
    .spawnX(spawnX), .spawnY(spawnY), .spawnStep(spawnStep), .spawnLife(spawnLife),
    .spawnAck(spawnAck), .spawnIdx(spawnIdx), .poolFull(poolFull),
    .killVec(killVec), .bounceVec(bounceVec), .existsVec(existsVec),
    .posXFlat(posXFlat), .posYFlat(posYFlat), .dirFlat(dirFlat),
    .activeCount(activeCount)
  );

  always #5 frameClk = ~frameClk;

  typedef struct {
    string       tag;
    int          kind;
    int          slot;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] observe(int kind, int slot);
    case (kind)
      K_ACK:    return 32'(spawnAck);
      K_IDX:    return 32'(spawnIdx);
      K_FULL:   return 32'(poolFull);
      K_CNT:    return 32'(activeCount);
      K_EXISTS: return 32'(existsVec);
      K_PX:     return 32'(posXFlat[slot*PW +: PW]);
      K_PY:     return 32'(posYFlat[slot*PW +: PW]);
      K_DIR:    return 32'(dirFlat[slot*2 +: 2]);
      default:  return 32'(dirFlat);
    endcase
  endfunction

  task automatic push(input string tag, input int kind, input int slot, input int exp);
    exp_t e;
    e.tag = tag; e.kind = kind; e.slot = slot; e.exp = 32'(exp);
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      obs = observe(e.kind, e.slot);
      checks++;
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge frameClk);
    #1;
  endtask

  task automatic set_spawn(input int x, input int y, input int d, input int st, input int lf);
    spawnReq = 1'b1;
    spawnX = PW'(x); spawnY = PW'(y); spawnDir = 2'(d);
    spawnStep = SW_'(st); spawnLife = LW'(lf);
  endtask

  initial begin
    tick(); tick();
    reset = 1'b0;
    #1;
    push("rst_exists", K_EXISTS, 0, 0); push("rst_cnt", K_CNT, 0, 0);
    push("rst_full", K_FULL, 0, 0); push("rst_dir", K_DIRALL, 0, 8'hFF);
    push("rst_px0", K_PX, 0, 0); push("rst_ack", K_ACK, 0, 0);
    drain();

    // basic spawn and movement
    set_spawn(100, 200, 3, 4, 0);
    #1;
    push("t1_ack", K_ACK, 0, 1); push("t1_idx", K_IDX, 0, 0);
    drain();
    tick(); spawnReq = 1'b0;
    push("t1_exists", K_EXISTS, 0, 4'b0001); push("t1_px", K_PX, 0, 100);
    push("t1_py", K_PY, 0, 200);
    drain();
    tick(); tick(); tick();
    push("t1_px_moved", K_PX, 0, 112); push("t1_py_moved", K_PY, 0, 200);
    drain();
    killVec = 4'b0001;
    tick(); killVec = '0;
    push("t1_kill", K_EXISTS, 0, 0); push("t1_kill_px", K_PX, 0, 112);
    drain();
    tick();
    push("t1_frozen_px", K_PX, 0, 112);
    drain();

    // fill the pool
    for (int k = 0; k < NB; k++) begin
      set_spawn(10 + 10 * k, 100, 3, 0, 2);
      #1;
      push($sformatf("fill_ack%0d", k), K_ACK, 0, 1);
      push($sformatf("fill_idx%0d", k), K_IDX, 0, k);
      drain();
      tick();
    end
    spawnReq = 1'b0;
    #1;
    push("fill_full", K_FULL, 0, 1); push("fill_cnt", K_CNT, 0, 4);
    push("fill_exists", K_EXISTS, 0, 4'b1111);
    drain();
    set_spawn(500, 300, 0, 1, 0);
    #1;
    push("full_ack", K_ACK, 0, 0); push("full_idx", K_IDX, 0, 0);
    drain();
    tick(); spawnReq = 1'b0;
    push("full_exists", K_EXISTS, 0, 4'b1111); push("full_px3", K_PX, 3, 40);
    push("full_cnt", K_CNT, 0, 4);
    drain();

    // kill while full: same-cycle request refused, next cycle reuses slot 1
    killVec = 4'b0010;
    set_spawn(300, 50, 3, 0, 0);
    #1;
    push("killfull_ack", K_ACK, 0, 0);
    drain();
    tick(); killVec = '0;
    push("killfull_exists", K_EXISTS, 0, 4'b1101); push("killfull_full", K_FULL, 0, 0);
    push("killfull_cnt", K_CNT, 0, 3); push("reuse_ack", K_ACK, 0, 1);
    push("reuse_idx", K_IDX, 0, 1);
    drain();
    tick(); spawnReq = 1'b0;
    push("reuse_exists", K_EXISTS, 0, 4'b1111); push("reuse_px1", K_PX, 1, 300);
    drain();

    // bounce budget on slot 0 (life=2)
    bounceVec = 4'b0001;
    tick();
    push("b1_dir", K_DIR, 0, 2); push("b1_exists", K_EXISTS, 0, 4'b1111);
    drain();
    tick();
    push("b2_dir", K_DIR, 0, 3); push("b2_exists", K_EXISTS, 0, 4'b1111);
    drain();
    tick(); bounceVec = '0;
    push("b3_exists", K_EXISTS, 0, 4'b1110); push("b3_dir", K_DIR, 0, 3);
    drain();

    // simultaneous kill and bounce on slot 2
    killVec = 4'b0100; bounceVec = 4'b0100;
    tick(); killVec = '0; bounceVec = '0;
    push("kb_exists", K_EXISTS, 0, 4'b1010); push("kb_dir", K_DIR, 2, 3);
    drain();

    // bounce then move in the new direction
    set_spawn(50, 60, 3, 5, 3);
    #1;
    push("bm_ack", K_ACK, 0, 1); push("bm_idx", K_IDX, 0, 0);
    drain();
    tick(); spawnReq = 1'b0;
    push("bm_px_spawn", K_PX, 0, 50); push("bm_exists", K_EXISTS, 0, 4'b1011);
    drain();
    bounceVec = 4'b0001;
    tick(); bounceVec = '0;
    push("bm_dir", K_DIR, 0, 2); push("bm_px_b", K_PX, 0, 45);
    drain();
    tick();
    push("bm_px_next", K_PX, 0, 40);
    drain();

    // upward edge crossing
    set_spawn(20, 2, 0, 4, 0);
    #1;
    push("edge_idx", K_IDX, 0, 2);
    drain();
    tick(); spawnReq = 1'b0;
    push("edge_py_spawn", K_PY, 2, 2); push("edge_exists0", K_EXISTS, 0, 4'b1111);
    drain();
    tick();
`ifdef BULLET_POOL_WRAP_EN
    push("edge_exists", K_EXISTS, 0, 4'b1111); push("edge_py", K_PY, 2, 478);
    push("edge_cnt", K_CNT, 0, 4);
`else
    push("edge_exists", K_EXISTS, 0, 4'b1011); push("edge_py", K_PY, 2, 2);
    push("edge_cnt", K_CNT, 0, 3);
`endif
    drain();

    // reset mid-flight beats a concurrent spawn
    reset = 1'b1;
    set_spawn(7, 7, 1, 1, 1);
    tick(); reset = 1'b0; spawnReq = 1'b0;
    push("mrst_exists", K_EXISTS, 0, 0); push("mrst_dir", K_DIRALL, 0, 8'hFF);
    push("mrst_px0", K_PX, 0, 0); push("mrst_cnt", K_CNT, 0, 0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
